// File: rtl/psum_collector_pkg.sv
// Shared types for the partial-sum collector. DATA_SIZE and ARRAY_COLS normally
// come from the shared define header; PSUM_COLLECT_RELU_EN enables the ReLU helper.
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif
`ifndef ARRAY_COLS
`define ARRAY_COLS 4
`endif

package psum_collector_pkg;
    localparam int DATA_W = `DATA_SIZE;

    typedef logic [DATA_W-1:0] data_t;

`ifdef PSUM_COLLECT_RELU_EN
    // Two's complement clamp: negative values become zero.
    function automatic data_t relu(input data_t v);
        return v[DATA_W-1] ? '0 : v;
    endfunction
`endif
endpackage

// File: rtl/psum_row_fifo.sv
// Row buffer for the collector: registered storage, no fall-through, extra
// pointer bit separates full from empty. Write while full succeeds only alongside a pop.
module psum_row_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_rd & ~o_empty;
    assign w_push  = i_wr & (~o_full | w_pop);
    assign o_valid = ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/psum_collector.sv
// Deskews systolic-array bottom-edge outputs into whole rows and buffers them.
// Optional: define PSUM_COLLECT_RELU_EN to clamp negative column values to zero.
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif
`ifndef ARRAY_COLS
`define ARRAY_COLS 4
`endif

module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int COLS       = `ARRAY_COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [7:0]             i_cfg_rows,
    input  logic [COLS*DATA_W-1:0] i_col_in,
    input  logic [COLS-1:0]        i_col_valid,
    output logic [COLS*DATA_W-1:0] o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err_ovf,
    output logic                   o_err_align
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             r_state;
    logic [7:0]             r_rows;
    logic [7:0]             r_cnt;
    logic                   r_zdone;
    logic                   r_err_ovf;
    logic                   r_err_align;

    logic [COLS-1:0][DATA_W-1:0] w_col_in;
    logic [COLS-1:0]             w_in_vld;
    data_t                       w_dsk_data [COLS];
    logic [COLS-1:0]             w_dsk_vld;
    logic [COLS-1:0][DATA_W-1:0] r_aln_data;
    logic [COLS-1:0]             r_aln_vld;
    logic [COLS-1:0][DATA_W-1:0] w_wr_data;

    logic w_attempt, w_wr, w_misal, w_drop, w_pop;
    logic w_fifo_valid, w_fifo_full, w_fifo_empty;

    assign w_col_in = i_col_in;
    // Outside COLLECT the lines fill with invalid slots, which flushes them.
    assign w_in_vld = (r_state == S_COLLECT) ? i_col_valid : '0;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int STAGES = COLS - 1 - c;
        if (STAGES == 0) begin : g_pass
            assign w_dsk_data[c] = w_col_in[c];
            assign w_dsk_vld[c]  = w_in_vld[c];
        end else begin : g_dly
            logic [STAGES-1:0]      r_vld_pipe;
            data_t                  r_dat_pipe [STAGES];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe[0] <= w_in_vld[c];
                    for (int s = 1; s < STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
                end
            end

            always_ff @(posedge i_clk) begin
                r_dat_pipe[0] <= w_col_in[c];
                for (int s = 1; s < STAGES; s++) r_dat_pipe[s] <= r_dat_pipe[s-1];
            end

            assign w_dsk_data[c] = r_dat_pipe[STAGES-1];
            assign w_dsk_vld[c]  = r_vld_pipe[STAGES-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_aln_vld <= '0;
        else       r_aln_vld <= w_dsk_vld;
        for (int c = 0; c < COLS; c++) r_aln_data[c] <= w_dsk_data[c];
    end

`ifdef PSUM_COLLECT_RELU_EN
    always_comb begin
        w_wr_data = r_aln_data;
        for (int c = 0; c < COLS; c++) w_wr_data[c] = relu(r_aln_data[c]);
    end
`else
    assign w_wr_data = r_aln_data;
`endif

    // Any deskewed valid counts as a row attempt, even if it is misaligned or dropped.
    assign w_attempt = (r_state == S_COLLECT) && (|r_aln_vld);
    assign w_wr      = w_attempt && (&r_aln_vld);
    assign w_misal   = w_attempt && !(&r_aln_vld);
    assign w_pop     = w_fifo_valid & i_out_ready;
    assign w_drop    = w_wr & w_fifo_full & ~w_pop;

    psum_row_fifo #(
        .WIDTH(COLS*DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (w_wr),
        .i_wdata(w_wr_data),
        .i_rd   (i_out_ready),
        .o_rdata(o_out_data),
        .o_valid(w_fifo_valid),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_cnt       <= '0;
            r_zdone     <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            r_zdone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_cfg_rows != 8'd0) begin
                            r_rows      <= i_cfg_rows;
                            r_cnt       <= '0;
                            r_err_ovf   <= 1'b0;
                            r_err_align <= 1'b0;
                            r_state     <= S_COLLECT;
                        end else begin
                            r_zdone <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_drop)  r_err_ovf   <= 1'b1;
                    if (w_misal) r_err_align <= 1'b1;
                    if (w_attempt) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == r_rows) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (w_fifo_empty) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_valid = w_fifo_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE) | r_zdone;
    assign o_err_ovf   = r_err_ovf;
    assign o_err_align = r_err_align;
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector at COLS=4, DATA_SIZE=16, FIFO_DEPTH=4.
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module tb_psum_collector;
    localparam int COLS = 4;
    localparam int DW   = `DATA_SIZE;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [7:0]           cfg_rows;
    logic [COLS*DW-1:0]   col_in;
    logic [COLS-1:0]      col_valid;
    logic [COLS*DW-1:0]   out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy, done, err_ovf, err_align;

    logic [DW-1:0]        rowv [0:7][0:COLS-1];
    int                   n_vec  = 0;
    int                   n_miss = 0;

    psum_collector #(.COLS(COLS), .FIFO_DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_cfg_rows (cfg_rows),
        .i_col_in   (col_in),
        .i_col_valid(col_valid),
        .o_out_data (out_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_err_ovf  (err_ovf),
        .o_err_align(err_align)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        return {rowv[r][3], rowv[r][2], rowv[r][1], rowv[r][0]};
    endfunction

    task automatic start_tile(input logic [7:0] rows);
        start    = 1'b1;
        cfg_rows = rows;
        step(1);
        start    = 1'b0;
    endtask

    // Presents n rows with column c of row r in cycle r+c; one slot may be withheld.
    task automatic feed(input int n, input int bad_r, input int bad_c);
        int r;
        for (int k = 0; k < n + COLS - 1; k++) begin
            for (int c = 0; c < COLS; c++) begin
                r = k - c;
                if (r >= 0 && r < n && !(r == bad_r && c == bad_c)) begin
                    col_valid[c]        = 1'b1;
                    col_in[c*DW +: DW]  = rowv[r][c];
                end else begin
                    col_valid[c]        = 1'b0;
                    col_in[c*DW +: DW]  = '0;
                end
            end
            step(1);
        end
        col_valid = '0;
        col_in    = '0;
    endtask

    task automatic single_row(input string pfx);
        out_ready = 1'b1;
        rowv[0][0] = 16'd10; rowv[0][1] = 16'd11; rowv[0][2] = 16'd12; rowv[0][3] = 16'd13;
        start_tile(8'd1);
        @(negedge clk);
        chk({pfx, "_busy_start"}, 64'(busy), 64'd1);
        feed(1, -1, -1);
        @(negedge clk);
        chk({pfx, "_not_early"}, 64'(out_valid), 64'd0);
        step(1); @(negedge clk);
        chk({pfx, "_valid_t5"}, 64'(out_valid), 64'd1);
        chk({pfx, "_data_t5"}, out_data, 64'h000D_000C_000B_000A);
        chk({pfx, "_done_early"}, 64'(done), 64'd0);
        step(1); @(negedge clk);
        chk({pfx, "_popped"}, 64'(out_valid), 64'd0);
        chk({pfx, "_drain_nodone"}, 64'(done), 64'd0);
        step(1); @(negedge clk);
        chk({pfx, "_done"}, 64'(done), 64'd1);
        chk({pfx, "_busy_done"}, 64'(busy), 64'd1);
        step(1); @(negedge clk);
        chk({pfx, "_done_1cyc"}, 64'(done), 64'd0);
        chk({pfx, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_rows = '0; col_in = '0; col_valid = '0; out_ready = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_errs",  64'({err_ovf, err_align}), 64'd0);
        chk("rst_data",  out_data, 64'd0);
        rst = 1'b0;
        step(1);

        single_row("s1");

        // Zero-row tile: immediate done, never busy.
        start_tile(8'd0);
        @(negedge clk);
        chk("z_done", 64'(done), 64'd1);
        chk("z_busy", 64'(busy), 64'd0);
        step(1); @(negedge clk);
        chk("z_done_1cyc", 64'(done), 64'd0);
        chk("z_busy2", 64'(busy), 64'd0);

        // Valids while idle must not reach the FIFO.
        col_valid = '1; col_in = '1;
        step(6);
        col_valid = '0; col_in = '0;
        step(2); @(negedge clk);
        chk("idle_ignore", 64'(out_valid), 64'd0);
        chk("idle_noerr", 64'(err_align), 64'd0);

        // Back-pressure: six rows into a four-deep FIFO.
        out_ready = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < COLS; c++) rowv[r][c] = 16'(16'h0100 * (r + 1) + c);
        start_tile(8'd6);
        feed(6, -1, -1);
        step(2); @(negedge clk);
        chk("bp_ovf",   64'(err_ovf), 64'd1);
        chk("bp_drain", 64'({busy, done}), 64'b10);
        chk("bp_head",  out_data, exp_row(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_pop%0d_v", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_pop%0d_d", i), out_data, exp_row(i));
            step(1); @(negedge clk);
        end
        chk("bp_empty", 64'(out_valid), 64'd0);
        step(1); @(negedge clk);
        chk("bp_done", 64'(done), 64'd1);
        step(2);

        // Misalignment: column 2 of row 0 missing.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < COLS; c++) rowv[r][c] = 16'(16'h0020 * (r + 1) + c);
        start_tile(8'd2);
        @(negedge clk);
        chk("ma_ovf_cleared", 64'(err_ovf), 64'd0);
        feed(2, 0, 2);
        @(negedge clk);
        chk("ma_err", 64'(err_align), 64'd1);
        chk("ma_nowrite", 64'(out_valid), 64'd0);
        step(1); @(negedge clk);
        chk("ma_row1_v", 64'(out_valid), 64'd1);
        chk("ma_row1_d", out_data, 64'h0043_0042_0041_0040);
        step(2); @(negedge clk);
        chk("ma_done", 64'(done), 64'd1);
        step(2);

        // Negative column value through the optional clamp.
        rowv[0][0] = 16'h0001; rowv[0][1] = 16'hFFF0; rowv[0][2] = 16'h0002; rowv[0][3] = 16'h0003;
        start_tile(8'd1);
        feed(1, -1, -1);
        step(1); @(negedge clk);
`ifdef PSUM_COLLECT_RELU_EN
        chk("relu_data", out_data, 64'h0003_0002_0000_0001);
`else
        chk("relu_data", out_data, 64'h0003_0002_FFF0_0001);
`endif
        step(4);

        // Reset with two rows buffered, mid-COLLECT.
        out_ready = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < COLS; c++) rowv[r][c] = 16'(16'h0300 + r * 16 + c);
        start_tile(8'd4);
        feed(2, -1, -1);
        step(1); @(negedge clk);
        chk("mr_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step(1); @(negedge clk);
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_busy",  64'(busy), 64'd0);
        chk("mr_done",  64'(done), 64'd0);
        chk("mr_data",  out_data, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1); @(negedge clk);
            chk($sformatf("mr_nodone%0d", i), 64'({done, out_valid}), 64'd0);
        end

        single_row("s2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
